rename_queue: RTL and testbench
===============================

Name: rename_queue

Overview:
- Decoupling FIFO between the decoder and the Rename stage.
- Buffers decoded instructions: instr, pc, arch regs and the 104-bit control word.
- Presents the oldest entry to Rename, which consumes it whenever the halt is low.
- When empty, presents a zero NOP bundle so Rename allocates nothing meaningful.
- Drops all contents on pipeline FLUSH.

Parameters:
- DEPTH, 8, number of entries; power of two, 2..64.
- AFULL_LVL, DEPTH-2, occupancy at or above which almost_full asserts.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- FLUSH  in  1  synchronous flush; empties the queue.
- in_valid  in  1  decoder presents a valid instruction.
- in_ready  out  1  queue can accept; equals !full.
- in_instr  in  32  instruction word.
- in_instrpc  in  32  instruction PC.
- in_RegA  in  5  architectural source A.
- in_RegB  in  5  architectural source B.
- in_RegWr  in  5  architectural destination.
- in_control  in  104  decoded control bundle; bit 99 = load, bit 98 = store, bit 96 = reg write.
- halt_rename_queue  in  1  Rename is stalled; head must not advance.
- out_valid  out  1  head entry valid.
- out_instr  out  32  head instruction; 0 when !out_valid.
- out_instrpc  out  32  head PC; 0 when !out_valid.
- out_RegA  out  5  head source A; 0 when !out_valid.
- out_RegB  out  5  head source B; 0 when !out_valid.
- out_RegWr  out  5  head destination; 0 when !out_valid.
- out_control  out  104  head control; 0 when !out_valid.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_LVL.
- count  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH x 183-bit entries {control, instr, pc, RegWr, RegB, RegA}.
- Pointers: head and tail, each clog2(DEPTH) bits, wrap modulo DEPTH naturally.
- Storage array is not reset; pointers and count are.
- Reset (async, any time, including mid-stream):
  - head=0, tail=0, count=0.
  - All outputs read 0 except in_ready=1.
- enq = in_valid & !full. On posedge, writes mem[tail]; tail+1.
- deq = out_valid & !halt_rename_queue. On posedge, head+1.
- Outputs are combinational from mem[head] gated by out_valid (out_valid = count!=0); no output register.
- Latency:
  - Entry enqueued at edge N is visible on out_* after edge N.
  - Minimum decode-to-Rename latency is one cycle.
- Simultaneous enq & deq:
  - Allowed when 0 < count < DEPTH; count unchanged.
  - When empty, only enq happens (no deq).
  - When full, only deq happens; the input is not accepted and the decoder must hold its data.
- in_valid while full: ignored. No overwrite, no state change from the enqueue side.
- FLUSH:
  - Has priority over enq/deq in the same cycle.
  - Next edge: head=tail=0, count=0; the entry being offered that cycle is dropped.
  - If FLUSH is held, the queue stays empty.
- halt_rename_queue high: head and outputs held stable; enq still accepted until full.
- Order: strict FIFO; no reordering or entry dropping except via FLUSH or reset.
- count arithmetic: +1 on enq only, -1 on deq only, unchanged on both or neither; never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: RENAME_QUEUE_BYPASS_EN.
- Defined:
  - When count==0, in_valid=1 and halt_rename_queue=0, out_* are driven directly from in_* with out_valid=1.
  - The instruction is consumed that cycle and not written to storage.
  - Zero-latency path when empty.
  - With halt high, or count>0, normal enqueue applies.
  - FLUSH still suppresses the bypass: out_valid=0 in a FLUSH cycle.
- Undefined: no bypass; the minimum latency is one cycle as above.

Test Plan:
- Reset: RESET=1 mid-stream with count=5 -> count=0, out_valid=0, out_instr=0, in_ready=1 immediately, before any clock edge.
- Fill and drain, DEPTH=8, halt=1:
  - Push instr 0x1..0x8 -> full=1 after the 8th edge; almost_full=1 from count=6; 9th push (0x9) ignored.
  - Release halt -> out_instr sequence 0x1..0x8 on successive cycles, then out_valid=0.
- Simultaneous enq/deq at count=3 for 20 cycles -> count stays 3; order preserved across pointer wrap; instrs exit in push order.
- Flush priority: count=4, FLUSH=1 with in_valid=1 (instr 0xAA) -> next edge count=0, out_valid=0; 0xAA never appears.
- Control passthrough: push in_control with bit99=1, RegWr=5, pc=0x400010 -> out_control bit99=1, out_RegWr=5, out_instrpc=0x400010 one cycle later.
- With RENAME_QUEUE_BYPASS_EN, empty, halt=0, in_instr=0x20020001 -> out_valid=1, out_instr=0x20020001 in the same cycle; count stays 0 after the edge.

Source files
------------

// File: rtl/rename_queue.sv
// rename_queue: decoupling FIFO between the decoder and the Rename stage.
// Holds DEPTH decoded instruction bundles of 183 bits each:
// {control[103:0], instr[31:0], pc[31:0], RegWr[4:0], RegB[4:0], RegA[4:0]}.
// The head entry is presented combinationally to Rename and retires on any
// clock edge where halt_rename_queue is low. An empty queue presents an
// all-zero NOP bundle. FLUSH empties the queue on the next edge.
// Optional feature macro: RENAME_QUEUE_BYPASS_EN (zero-latency bypass of an
// incoming instruction straight to the outputs when the queue is empty).

module rename_queue #(
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      FLUSH,

    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_instr,
    input  logic [31:0]               in_instrpc,
    input  logic [4:0]                in_RegA,
    input  logic [4:0]                in_RegB,
    input  logic [4:0]                in_RegWr,
    input  logic [103:0]              in_control,

    input  logic                      halt_rename_queue,
    output logic                      out_valid,
    output logic [31:0]               out_instr,
    output logic [31:0]               out_instrpc,
    output logic [4:0]                out_RegA,
    output logic [4:0]                out_RegB,
    output logic [4:0]                out_RegWr,
    output logic [103:0]              out_control,

    output logic                      full,
    output logic                      almost_full,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 183;

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;

    logic               stored_valid;
    logic               bypass;
    logic               enq;
    logic               deq;

    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [ENTRY_W-1:0] out_entry;

    assign in_entry     = {in_control, in_instr, in_instrpc, in_RegWr, in_RegB, in_RegA};
    assign head_entry   = mem[head];

    assign stored_valid = (count != '0);
    assign full         = (count == CNT_W'(DEPTH));
    assign almost_full  = (count >= CNT_W'(AFULL_LVL));
    assign in_ready     = ~full;

`ifdef RENAME_QUEUE_BYPASS_EN
    // An instruction arriving at an empty, unstalled queue goes straight to
    // Rename and is consumed this cycle, so it is never written to storage.
    // Reset and flush both kill the bypass so the outputs stay zero.
    assign bypass = ~stored_valid & in_valid & ~halt_rename_queue & ~FLUSH & ~RESET;
`else
    assign bypass = 1'b0;
`endif

    // Enqueue only when there is room; a bypassed instruction is not stored.
    assign enq = in_valid & ~full & ~bypass;
    // The head retires whenever a stored entry is shown and Rename is not halted.
    assign deq = stored_valid & ~halt_rename_queue;

    // Head/tail pointers and occupancy; flush has priority over enq/deq.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (FLUSH) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (deq) begin
                head <= head + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage is deliberately left unreset; valid data is tracked by count.
    always_ff @(posedge CLK) begin
        if (enq && !FLUSH) begin
            mem[tail] <= in_entry;
        end
    end

    // Select the bundle shown to Rename, forcing a zero NOP when nothing is valid.
    always_comb begin
        out_valid = stored_valid | bypass;
        out_entry = '0;
        if (bypass) begin
            out_entry = in_entry;
        end else if (stored_valid) begin
            out_entry = head_entry;
        end
    end

    assign out_control = out_entry[182:79];
    assign out_instr   = out_entry[78:47];
    assign out_instrpc = out_entry[46:15];
    assign out_RegWr   = out_entry[14:10];
    assign out_RegB    = out_entry[9:5];
    assign out_RegA    = out_entry[4:0];

endmodule

// File: tb/tb_rename_queue.sv
// tb_rename_queue: directed, scoreboard-checked bench for rename_queue.
// Stimulus pushes the expected bundle of every instruction the queue should
// accept; an independent monitor pops and compares whenever Rename consumes.
// Build with +define+RENAME_QUEUE_BYPASS_EN to also cover the bypass path.

module tb_rename_queue;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               CLK = 1'b0;
    logic               RESET;
    logic               FLUSH;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_instr;
    logic [31:0]        in_instrpc;
    logic [4:0]         in_RegA;
    logic [4:0]         in_RegB;
    logic [4:0]         in_RegWr;
    logic [103:0]       in_control;
    logic               halt_rename_queue;
    logic               out_valid;
    logic [31:0]        out_instr;
    logic [31:0]        out_instrpc;
    logic [4:0]         out_RegA;
    logic [4:0]         out_RegB;
    logic [4:0]         out_RegWr;
    logic [103:0]       out_control;
    logic               full;
    logic               almost_full;
    logic [CNT_W-1:0]   count;

    logic [182:0]       sb [$];
    int                 n_checks = 0;
    int                 n_errors = 0;
    int                 model_count = 0;
    logic [182:0]       mon_got;
    logic [182:0]       mon_exp;

    always #5 CLK = ~CLK;

    rename_queue #(
        .DEPTH     (DEPTH),
        .AFULL_LVL (DEPTH - 2)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .FLUSH             (FLUSH),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_instr          (in_instr),
        .in_instrpc        (in_instrpc),
        .in_RegA           (in_RegA),
        .in_RegB           (in_RegB),
        .in_RegWr          (in_RegWr),
        .in_control        (in_control),
        .halt_rename_queue (halt_rename_queue),
        .out_valid         (out_valid),
        .out_instr         (out_instr),
        .out_instrpc       (out_instrpc),
        .out_RegA          (out_RegA),
        .out_RegB          (out_RegB),
        .out_RegWr         (out_RegWr),
        .out_control       (out_control),
        .full              (full),
        .almost_full       (almost_full),
        .count             (count)
    );

    // Compare one scalar observation against its hand-computed value.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs and record what the queue should do with them.
    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                                 input logic [103:0] ctrl, input logic halt, input logic flush);
        logic byp;
        logic do_enq;
        logic do_deq;
        in_valid          = v;
        in_instr          = instr;
        in_instrpc        = pc;
        in_RegA           = ra;
        in_RegB           = rb;
        in_RegWr          = rw;
        in_control        = ctrl;
        halt_rename_queue = halt;
        FLUSH             = flush;
        if (flush) begin
            sb.delete();
            model_count = 0;
        end else begin
            byp = 1'b0;
`ifdef RENAME_QUEUE_BYPASS_EN
            byp = v && (model_count == 0) && !halt;
`endif
            do_enq = v && (model_count < DEPTH) && !byp;
            do_deq = (model_count != 0) && !halt;
            if (byp || do_enq) begin
                sb.push_back({ctrl, instr, pc, rw, rb, ra});
            end
            model_count = model_count + (do_enq ? 1 : 0) - (do_deq ? 1 : 0);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive an instruction whose other fields are derived from its word.
    task automatic driveDefault(input logic v, input logic [31:0] instr, input logic halt, input logic flush);
        applyStimulus(v, instr, 32'h1000 + (instr << 2), instr[4:0], instr[9:5], instr[14:10],
                      {8'h00, ~instr, instr, instr}, halt, flush);
    endtask

    task automatic cycleDefault(input logic v, input logic [31:0] instr, input logic halt, input logic flush);
        driveDefault(v, instr, halt, flush);
        tick();
    endtask

    // Monitor: on the falling edge, a shown, unhalted, unflushed head is consumed.
    always @(negedge CLK) begin
        if (!RESET) begin
            mon_got = {out_control, out_instr, out_instrpc, out_RegWr, out_RegB, out_RegA};
            if (out_valid && !halt_rename_queue && !FLUSH) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("[TB] FAIL unexpected_output: got instr %0h, expected no valid output", out_instr);
                end else begin
                    mon_exp = sb.pop_front();
                    if (mon_got !== mon_exp) begin
                        n_errors++;
                        $display("[TB] FAIL head_bundle: got %0h, expected %0h", mon_got, mon_exp);
                    end
                end
            end else if (!out_valid) begin
                n_checks++;
                if (mon_got !== '0) begin
                    n_errors++;
                    $display("[TB] FAIL nop_bundle: got %0h, expected 0", mon_got);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [103:0] ctrl;

        RESET             = 1'b1;
        FLUSH             = 1'b0;
        in_valid          = 1'b0;
        in_instr          = '0;
        in_instrpc        = '0;
        in_RegA           = '0;
        in_RegB           = '0;
        in_RegWr          = '0;
        in_control        = '0;
        halt_rename_queue = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;

        checkOutput("rst_count", count, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_almost_full", almost_full, 0);
        checkOutput("rst_out_instr", out_instr, 0);

        // Fill while Rename is halted.
        for (int i = 1; i <= 8; i++) begin
            cycleDefault(1'b1, 32'(i), 1'b1, 1'b0);
            checkOutput("fill_count", count, i);
            checkOutput("fill_almost_full", almost_full, (i >= 6) ? 1 : 0);
            checkOutput("fill_full", full, (i == 8) ? 1 : 0);
        end
        cycleDefault(1'b1, 32'h9, 1'b1, 1'b0);
        checkOutput("overflow_count", count, 8);
        checkOutput("overflow_full", full, 1);
        checkOutput("overflow_in_ready", in_ready, 0);
        checkOutput("halt_head_instr", out_instr, 32'h1);

        // Release the halt and drain in order.
        for (int i = 0; i < 8; i++) begin
            cycleDefault(1'b0, 32'h0, 1'b0, 1'b0);
        end
        checkOutput("drain_count", count, 0);
        checkOutput("drain_out_valid", out_valid, 0);
        checkOutput("drain_out_instr", out_instr, 0);

        // Steady enqueue and dequeue at occupancy three, wrapping the pointers.
        for (int i = 0; i < 3; i++) begin
            cycleDefault(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
        end
        checkOutput("steady_start_count", count, 3);
        for (int k = 0; k < 20; k++) begin
            cycleDefault(1'b1, 32'h103 + 32'(k), 1'b0, 1'b0);
            checkOutput("steady_count", count, 3);
        end
        for (int i = 0; i < 3; i++) begin
            cycleDefault(1'b0, 32'h0, 1'b0, 1'b0);
        end
        checkOutput("steady_drain_count", count, 0);

        // Flush beats a simultaneous enqueue; 0xAA must never come out.
        for (int i = 0; i < 4; i++) begin
            cycleDefault(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
        end
        checkOutput("preflush_count", count, 4);
        cycleDefault(1'b1, 32'hAA, 1'b0, 1'b1);
        checkOutput("flush_count", count, 0);
        checkOutput("flush_out_valid", out_valid, 0);
        cycleDefault(1'b1, 32'hBB, 1'b0, 1'b1);
        checkOutput("flush_held_count", count, 0);
        cycleDefault(1'b0, 32'h0, 1'b0, 1'b0);
        cycleDefault(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("postflush_count", count, 0);
        checkOutput("postflush_out_valid", out_valid, 0);

        // Control, destination and PC pass through unchanged.
        ctrl      = '0;
        ctrl[99]  = 1'b1;
        ctrl[96]  = 1'b1;
        applyStimulus(1'b1, 32'h00A00093, 32'h00400010, 5'd1, 5'd2, 5'd5, ctrl, 1'b1, 1'b0);
        #1;
        checkOutput("pass_before_edge_valid", out_valid, 0);
        tick();
        checkOutput("pass_out_valid", out_valid, 1);
        checkOutput("pass_control_load", out_control[99], 1);
        checkOutput("pass_control_regwrite", out_control[96], 1);
        checkOutput("pass_RegWr", out_RegWr, 5);
        checkOutput("pass_instrpc", out_instrpc, 32'h00400010);
        cycleDefault(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("pass_drain_count", count, 0);

        // Asynchronous reset in the middle of a stream with five entries held.
        for (int i = 0; i < 5; i++) begin
            cycleDefault(1'b1, 32'h300 + 32'(i), 1'b1, 1'b0);
        end
        checkOutput("prereset_count", count, 5);
        driveDefault(1'b0, 32'h0, 1'b1, 1'b0);
        RESET = 1'b1;
        sb.delete();
        model_count = 0;
        #1;
        checkOutput("async_rst_count", count, 0);
        checkOutput("async_rst_out_valid", out_valid, 0);
        checkOutput("async_rst_out_instr", out_instr, 0);
        checkOutput("async_rst_in_ready", in_ready, 1);
        tick();
        RESET = 1'b0;
        cycleDefault(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("after_rst_count", count, 0);

`ifdef RENAME_QUEUE_BYPASS_EN
        // Empty and unstalled: the instruction reaches Rename in the same cycle.
        driveDefault(1'b1, 32'h20020001, 1'b0, 1'b0);
        #1;
        checkOutput("bypass_out_valid", out_valid, 1);
        checkOutput("bypass_out_instr", out_instr, 32'h20020001);
        tick();
        checkOutput("bypass_count", count, 0);
        cycleDefault(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("bypass_after_valid", out_valid, 0);
`endif

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
